// File: rtl/wdt_timeout_ctrl.sv
// rtl/wdt_timeout_ctrl.sv - watchdog two-stage (warning, then bite) timeout controller
module wdt_timeout_ctrl #(
  parameter int unsigned RST_PULSE_W = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      cr1in,
  input  logic [CNT_W-1:0] cr2,
  input  logic [CNT_W-1:0] icr,
  output logic             cr1out,
  output logic             wdt_int,
  output logic             wdt_rst_n,
  output logic [2:0]       wdt_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_COUNT = 3'b001,
    S_WARN  = 3'b010,
    S_BITE  = 3'b011,
    S_HOLD  = 3'b100
  } state_t;

  // The pulse counter is 8 bits wide because the pulse width is limited to 1..255 cycles
  localparam logic [7:0]       PULSE_LAST = 8'(RST_PULSE_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  // Input capture stage
  logic r_kick_d;
  logic r_kick;
  logic r_exp;
  logic r_en;
  logic r_inten;
  logic r_rsten;

  // FSM and counters
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] w_wcnt_nxt;
  logic [7:0]       r_pcnt;
  logic [7:0]       w_pcnt_nxt;

  // Registered outputs
  logic r_cr1out;
  logic r_int;
  logic r_rst_n;
  logic w_cr1out_nxt;
  logic w_int_nxt;
  logic w_rst_n_nxt;
  logic w_alarm;

  // Event decode
  logic           w_kick_edge;
  logic           w_exp;
  logic [CNT_W:0] w_wcnt_inc;
  logic           w_warn_done;
  logic           w_pulse_done;
  logic           w_unused;

  // Only the rising edge of KICK is an event; a held KICK bit is a single kick
  assign w_kick_edge = cr1in[4] & ~r_kick_d;

  // Greater-or-equal so a counter value that jumps past the timeout still expires
  assign w_exp = (cr2 != '0) && (icr >= cr2);

  // One extra bit so the +1 at a saturated counter does not wrap back to zero
  assign w_wcnt_inc  = {1'b0, r_wcnt} + {{CNT_W{1'b0}}, 1'b1};

  // A zero timeout freezes the warning window open until a kick or disable
  assign w_warn_done  = (cr2 != '0) && (w_wcnt_inc >= {1'b0, cr2});
  assign w_pulse_done = (r_pcnt == PULSE_LAST);

  // Status feedback bit and reserved control bits carry no function here
  assign w_unused = ^{cr1in[31:5], cr1in[3]};

  // Capture control bits and derived kick/expiry events so the FSM acts on aligned, registered inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_kick_d <= 1'b0;
      r_kick   <= 1'b0;
      r_exp    <= 1'b0;
      r_en     <= 1'b0;
      r_inten  <= 1'b0;
      r_rsten  <= 1'b0;
    end else begin
      r_kick_d <= cr1in[4];
      r_kick   <= w_kick_edge;
      r_exp    <= w_exp;
      r_en     <= cr1in[0];
      r_inten  <= cr1in[1];
      r_rsten  <= cr1in[2];
    end
  end

  // Next-state, counter and output decode; disable beats kick, and kick beats warning expiry
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_pcnt_nxt  = r_pcnt;

    case (r_state)
      S_IDLE: begin
        if (r_en) begin
          w_state_nxt = S_COUNT;
        end
      end

      S_COUNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_exp) begin
          w_state_nxt = S_WARN;
          w_wcnt_nxt  = '0;
        end
      end

      S_WARN: begin
        if (r_wcnt != CNT_MAX) begin
          w_wcnt_nxt = r_wcnt + CNT_ONE;
        end
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_kick) begin
          w_state_nxt = S_COUNT;
        end else if (w_warn_done) begin
          w_state_nxt = r_rsten ? S_BITE : S_HOLD;
          w_pcnt_nxt  = '0;
        end
      end

      // The reset pulse always runs to completion; enable and kick are not looked at
      S_BITE: begin
        if (w_pulse_done) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_pcnt_nxt = r_pcnt + 8'd1;
        end
      end

      S_HOLD: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_kick) begin
          w_state_nxt = S_COUNT;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state
    w_alarm      = (w_state_nxt == S_WARN) || (w_state_nxt == S_BITE) || (w_state_nxt == S_HOLD);
    w_cr1out_nxt = w_alarm;
    w_int_nxt    = w_alarm & r_inten;
    w_rst_n_nxt  = (w_state_nxt != S_BITE);
  end

  // State, counters and registered outputs; reset releases the reset request immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_pcnt   <= '0;
      r_cr1out <= 1'b0;
      r_int    <= 1'b0;
      r_rst_n  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_pcnt   <= w_pcnt_nxt;
      r_cr1out <= w_cr1out_nxt;
      r_int    <= w_int_nxt;
      r_rst_n  <= w_rst_n_nxt;
    end
  end

  assign cr1out    = r_cr1out;
  assign wdt_int   = r_int;
  assign wdt_rst_n = r_rst_n;
  assign wdt_state = r_state;

endmodule

// File: tb/tb_wdt_timeout_ctrl.sv
// tb/tb_wdt_timeout_ctrl.sv - self-checking bench for wdt_timeout_ctrl
module tb_wdt_timeout_ctrl;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cr1in;
  logic [31:0] cr2;
  logic [31:0] icr;
  logic        cr1out;
  logic        wdt_int;
  logic        wdt_rst_n;
  logic [2:0]  wdt_state;

  wdt_timeout_ctrl #(.RST_PULSE_W(W), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cr1in(cr1in), .cr2(cr2), .icr(icr),
    .cr1out(cr1out), .wdt_int(wdt_int), .wdt_rst_n(wdt_rst_n), .wdt_state(wdt_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: timestamps of entering warning / bite, plus last cycle's sampled controls
  int     ms;
  longint cyc = 0;
  longint warn_t;
  longint bite_t;
  bit     pe, pi, pr, pk, pk4, px;
  bit     e_cr1, e_int, e_rstn;

  logic [31:0] u_icr = 32'd0;
  logic [27:0] junk  = 28'd0;

  typedef struct packed {
    logic en; logic inten; logic rsten; logic k4;
    logic [31:0] c2; logic [31:0] ic;
    logic o_cr1; logic o_int; logic o_rstn; logic [2:0] o_st;
  } vec_t;
  vec_t tbl [15];

  function automatic vec_t mk(input logic en, inten, rsten, k4, input logic [31:0] c2, ic,
                              input logic o_cr1, o_int, o_rstn, input logic [2:0] o_st);
    vec_t v;
    v.en = en; v.inten = inten; v.rsten = rsten; v.k4 = k4; v.c2 = c2; v.ic = ic;
    v.o_cr1 = o_cr1; v.o_int = o_int; v.o_rstn = o_rstn; v.o_st = o_st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; pe = 0; pi = 0; pr = 0; pk = 0; pk4 = 0; px = 0;
    e_cr1 = 0; e_int = 0; e_rstn = 1;
  endtask

  // States follow the published encoding: 0 idle, 1 count, 2 warn, 3 bite, 4 hold
  task automatic model_edge(input bit en, inten, rsten, k4, input logic [31:0] c2, ic);
    int ns;
    cyc++;
    ns = ms;
    case (ms)
      0: if (pe) ns = 1;
      1: if (!pe) ns = 0; else if (px) begin ns = 2; warn_t = cyc; end
      2: if (!pe) ns = 0;
         else if (pk) ns = 1;
         else if (c2 != 0 && (cyc - warn_t) >= longint'(c2)) begin ns = pr ? 3 : 4; bite_t = cyc; end
      3: if ((cyc - bite_t) >= W) ns = 4;
      4: if (!pe) ns = 0; else if (pk) ns = 1;
      default: ns = 0;
    endcase
    e_cr1  = (ns >= 2);
    e_int  = (ns >= 2) && pi;
    e_rstn = (ns != 3);
    ms = ns;
    pe = en; pi = inten; pr = rsten;
    pk = k4 && !pk4; pk4 = k4;
    px = (c2 != 0) && (ic >= c2);
  endtask

  task automatic step(input bit en, inten, rsten, k4, input logic [31:0] c2, ic);
    cr1in = {junk[27:1], k4, junk[0], rsten, inten, en};
    cr2 = c2;
    icr = ic;
    @(posedge clk);
    model_edge(en, inten, rsten, k4, c2, ic);
    #1;
    check("m_cr1out", cr1out, e_cr1);
    check("m_wdt_int", wdt_int, e_int);
    check("m_wdt_rst_n", wdt_rst_n, e_rstn);
    check("m_wdt_state", wdt_state, ms);
  endtask

  // Upstream counter: cleared while KICK is held, otherwise counting
  task automatic tick(input bit en, inten, rsten, k4, input logic [31:0] c2);
    if (k4) u_icr = 32'd0;
    step(en, inten, rsten, k4, c2, u_icr);
    u_icr = u_icr + 32'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout: simulation did not finish");
    $fatal(1);
  end

  int  i_icr10, i_rise, i_fall, i_up, cnt;
  logic [2:0] st_up;
  bit  found, nodrop;
  bit  r_en_r, r_int_r, r_rst_r, r_k4;
  logic [31:0] r_c2;

  initial begin
    tbl[0]  = mk(1,1,0,0,3,0, 0,0,1,3'd0);
    tbl[1]  = mk(1,1,0,0,3,1, 0,0,1,3'd1);
    tbl[2]  = mk(1,1,0,0,3,2, 0,0,1,3'd1);
    tbl[3]  = mk(1,1,0,0,3,3, 0,0,1,3'd1);
    tbl[4]  = mk(1,1,0,0,3,4, 1,1,1,3'd2);
    tbl[5]  = mk(1,1,0,0,3,5, 1,1,1,3'd2);
    tbl[6]  = mk(1,1,0,0,3,6, 1,1,1,3'd2);
    tbl[7]  = mk(1,1,0,0,3,7, 1,1,1,3'd4);
    tbl[8]  = mk(1,0,0,0,3,8, 1,1,1,3'd4);
    tbl[9]  = mk(1,1,0,0,3,9, 1,0,1,3'd4);
    tbl[10] = mk(1,1,0,1,3,0, 1,1,1,3'd4);
    tbl[11] = mk(1,1,0,0,3,0, 0,0,1,3'd1);
    tbl[12] = mk(1,1,0,0,3,1, 0,0,1,3'd1);
    tbl[13] = mk(0,1,0,0,3,2, 0,0,1,3'd1);
    tbl[14] = mk(0,1,0,0,3,3, 0,0,1,3'd0);

    rst = 1'b0; cr1in = 32'd0; cr2 = 32'd0; icr = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cr1out", cr1out, 0);
    check("rst_wdt_int", wdt_int, 0);
    check("rst_wdt_rst_n", wdt_rst_n, 1);
    check("rst_wdt_state", wdt_state, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].en, tbl[i].inten, tbl[i].rsten, tbl[i].k4, tbl[i].c2, tbl[i].ic);
      check($sformatf("T%0d_cr1out", i), cr1out, tbl[i].o_cr1);
      check($sformatf("T%0d_wdt_int", i), wdt_int, tbl[i].o_int);
      check($sformatf("T%0d_wdt_rst_n", i), wdt_rst_n, tbl[i].o_rstn);
      check($sformatf("T%0d_wdt_state", i), wdt_state, tbl[i].o_st);
    end

    // Basic expiry with a 10-cycle window and a full reset pulse
    u_icr = 32'd0;
    tick(1,1,1,1,10);
    i_icr10 = -1; i_rise = -1; i_fall = -1; i_up = -1; st_up = 3'd7;
    for (int i = 0; i < 80 && i_up < 0; i++) begin
      if (u_icr == 32'd10 && i_icr10 < 0) i_icr10 = i;
      tick(1,1,1,0,10);
      if (cr1out && i_rise < 0) i_rise = i;
      if (!wdt_rst_n && i_fall < 0) i_fall = i;
      if (wdt_rst_n && i_fall >= 0 && i_up < 0) begin i_up = i; st_up = wdt_state; end
    end
    check("A_expiry_latency", i_rise - i_icr10, 1);
    check("A_warn_window", i_fall - i_rise, 10);
    check("A_pulse_width", i_up - i_fall, W);
    check("A_hold_after_bite", st_up, 3'd4);

    // Kick three cycles into the warning window
    tick(1,1,1,1,8);
    found = 0; nodrop = 1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1,1,1,0,8);
      if (wdt_state == 3'd2) found = 1;
    end
    check("B_warn_reached", found, 1);
    repeat (2) begin tick(1,1,1,0,8); if (!wdt_rst_n) nodrop = 0; end
    tick(1,1,1,1,8);
    repeat (4) begin tick(1,1,1,0,8); if (!wdt_rst_n) nodrop = 0; end
    check("B_state_count", wdt_state, 3'd1);
    check("B_cr1out_clear", cr1out, 0);
    check("B_int_clear", wdt_int, 0);
    check("B_no_reset", nodrop, 1);

    // Reset disabled: warning goes straight to hold
    tick(1,1,0,1,5);
    found = 0; nodrop = 1; cnt = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1,1,0,0,5);
      if (wdt_state == 3'd2) found = 1;
    end
    cnt = found ? 1 : 0;
    for (int i = 0; i < 20 && wdt_state == 3'd2; i++) begin
      tick(1,1,0,0,5);
      if (!wdt_rst_n) nodrop = 0;
      if (wdt_state == 3'd2) cnt++;
    end
    check("C_warn_cycles", cnt, 5);
    check("C_state_hold", wdt_state, 3'd4);
    check("C_cr1out_held", cr1out, 1);
    check("C_no_reset", nodrop, 1);

    // Zero timeout disables expiry even at the counter maximum
    tick(1,1,1,1,0);
    tick(1,1,1,0,0);
    for (int i = 0; i < 16; i++) step(1,1,1,0,32'd0, 32'hFFFF_FFF0 + 32'(i));
    check("D_state_count", wdt_state, 3'd1);
    check("D_outputs_idle", {cr1out, wdt_int, wdt_rst_n}, 3'b001);

    // Disable and kick together in warning: disable wins
    tick(1,1,1,1,6);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1,1,1,0,6);
      if (wdt_state == 3'd2) found = 1;
    end
    check("E_warn_reached", found, 1);
    tick(0,1,1,1,6);
    tick(0,1,1,0,6);
    check("E_state_idle", wdt_state, 3'd0);
    check("E_cr1out_clear", cr1out, 0);

    // Disable during bite: pulse still completes
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1,1,1,0,4);
      if (wdt_state == 3'd3) found = 1;
    end
    check("F_bite_reached", found, 1);
    cnt = (!wdt_rst_n) ? 1 : 0;
    st_up = 3'd7;
    for (int i = 0; i < 40; i++) begin
      tick(0,1,1,0,4);
      if (!wdt_rst_n) cnt++;
      else begin st_up = wdt_state; break; end
    end
    check("F_pulse_width", cnt, W);
    check("F_hold_after_bite", st_up, 3'd4);
    tick(0,1,1,0,4);
    check("F_idle_after_hold", wdt_state, 3'd0);

    // Asynchronous reset in the middle of the bite pulse
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1,1,1,0,4);
      if (wdt_state == 3'd3) found = 1;
    end
    check("G_bite_reached", found, 1);
    repeat (4) tick(1,1,1,0,4);
    #1 rst = 1'b0;
    #1;
    check("G_rst_n_async", wdt_rst_n, 1);
    check("G_state_async", wdt_state, 3'd0);
    check("G_cr1out_async", cr1out, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(1,1,1,0,0);
    tick(1,1,1,0,0);
    check("G_restart_count", wdt_state, 3'd1);

    // Randomized traffic against the model
    r_en_r = 1; r_int_r = 1; r_rst_r = 1; r_k4 = 0; r_c2 = 32'd6;
    for (int i = 0; i < 2500; i++) begin
      junk = 28'($urandom);
      r_en_r = ($urandom_range(99) < 97);
      if ($urandom_range(99) < 3) r_int_r = ~r_int_r;
      if ($urandom_range(99) < 2) r_rst_r = ~r_rst_r;
      if ($urandom_range(99) < 3) r_c2 = ($urandom_range(19) == 0) ? 32'd0 : 32'($urandom_range(14, 1));
      if (r_k4) r_k4 = ($urandom_range(1) == 0);
      else      r_k4 = ($urandom_range(99) < 4);
      if ($urandom_range(99) == 0) u_icr = u_icr + 32'($urandom_range(50));
      tick(r_en_r, r_int_r, r_rst_r, r_k4, r_c2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
